crc16_frame_tx: RTL

CRC16_FRAME_TX -- requirements
Module: crc16_frame_tx

---
 rtl/crc16_pkg.sv | 14 +
 rtl/crc16_bitser_core.sv | 46 ++++
 rtl/crc16_frame_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/crc16_pkg.sv
// Shared constants and FSM state type for the CRC-16 (ISO 14443-A style) frame transmitter.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY_A = 16'h8408;
  localparam logic [15:0] CRC16_INIT_A = 16'h6363;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CRC_LO = 2'd2,
    CRC_HI = 2'd3
  } crc16_state_t;

endpackage

// File: rtl/crc16_bitser_core.sv
// Bit-serial reflected CRC-16 engine: load XORs a byte into crc[7:0], then 8 shift cycles.
module crc16_bitser_core #(
  parameter logic [15:0] POLY = 16'h8408,
  parameter logic [15:0] INIT = 16'h6363
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [7:0]  i_data,
  input  logic        i_init,
  output logic [15:0] o_crc,
  output logic        o_done
);

  logic [15:0] r_crc;
  logic [2:0]  r_cnt;
  logic        r_active;
  logic [15:0] w_shifted;

  assign w_shifted = (r_crc >> 1) ^ (r_crc[0] ? POLY : 16'h0000);

  // i_init wins over an in-flight shift so a frame can be dropped on its done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc    <= INIT;
      r_cnt    <= 3'd0;
      r_active <= 1'b0;
    end else if (i_init) begin
      r_crc    <= INIT;
      r_cnt    <= 3'd0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_crc    <= {r_crc[15:8], r_crc[7:0] ^ i_data};
      r_cnt    <= 3'd0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_crc <= w_shifted;
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) r_active <= 1'b0;
    end
  end

  assign o_crc  = r_crc;
  assign o_done = r_active && (r_cnt == 3'd7);

endmodule

// File: rtl/crc16_frame_tx.sv
// Frame transmitter: forwards payload bytes and appends CRC lo/hi bytes.
// Optional build macro CRC16_TX_SKIP_EN adds crc_skip (per-frame CRC suppression).
module crc16_frame_tx
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY_A,
  parameter logic [15:0] INIT = CRC16_INIT_A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic [1:0] o_dbg_state
`ifdef CRC16_TX_SKIP_EN
  ,
  input  logic       crc_skip
`endif
);

  // Handshake: a byte moves on in_valid&in_ready, out_* moves on out_valid&out_ready;
  // out_* stay stable while out_valid=1 and out_ready=0.

  crc16_state_t r_state, w_next;
  logic [7:0]   r_out_data;
  logic         r_out_valid;
  logic         r_out_last;
  logic         r_last;
  logic         r_busy;
  logic [15:0]  w_crc;
  logic         w_done;
  logic         w_load;
  logic         w_init;
  logic         w_accept;
  logic         w_crc_phase;
  logic         w_crc_xfer;
  logic         w_skip_sel;
  logic         w_skip_frame;
  logic         w_frame_end;

`ifdef CRC16_TX_SKIP_EN
  logic r_skip;
  // Skip is captured with the first byte; later bytes of the frame reuse it.
  assign w_skip_sel   = r_busy ? r_skip : crc_skip;
  assign w_skip_frame = r_skip;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_skip <= 1'b0;
    else if (w_accept && !r_busy) r_skip <= crc_skip;
  end
`else
  assign w_skip_sel   = 1'b0;
  assign w_skip_frame = 1'b0;
`endif

  crc16_bitser_core #(.POLY(POLY), .INIT(INIT)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_data (in_data),
    .i_init (w_init),
    .o_crc  (w_crc),
    .o_done (w_done)
  );

  assign in_ready    = rst_n && (r_state == IDLE) && !r_out_valid;
  assign w_accept    = in_valid && in_ready;
  // CRC bytes only appear once the last payload byte has left the output register.
  assign w_crc_phase = ((r_state == CRC_LO) || (r_state == CRC_HI)) && !r_out_valid;
  assign w_crc_xfer  = w_crc_phase && out_ready;
  assign w_frame_end = ((r_state == CRC_HI) && w_crc_xfer) ||
                       ((r_state == SHIFT) && w_done && r_last && w_skip_frame);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_init = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = SHIFT;
          w_load = 1'b1;
        end
      end
      SHIFT: begin
        if (w_done) begin
          if (!r_last) begin
            w_next = IDLE;
          end else if (w_skip_frame) begin
            w_next = IDLE;
            w_init = 1'b1;
          end else begin
            w_next = CRC_LO;
          end
        end
      end
      CRC_LO: begin
        if (w_crc_xfer) w_next = CRC_HI;
      end
      CRC_HI: begin
        if (w_crc_xfer) begin
          w_next = IDLE;
          w_init = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_data  <= in_data;
        r_out_valid <= 1'b1;
        r_out_last  <= in_last && w_skip_sel;
        r_last      <= in_last;
        r_busy      <= 1'b1;
      end else begin
        if (r_out_valid && out_ready) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
        if (w_frame_end) begin
          r_busy <= 1'b0;
          r_last <= 1'b0;
        end
      end
    end
  end

  assign out_valid   = r_out_valid || w_crc_phase;
  assign out_data    = !w_crc_phase ? r_out_data :
                       (r_state == CRC_LO) ? w_crc[7:0] : w_crc[15:8];
  assign out_last    = w_crc_phase ? (r_state == CRC_HI) : r_out_last;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule
